// File: rtl/uart_loader.sv
// UART 8N1 program loader: turns received bytes into zero-extended words at
// word-aligned addresses and flags completion after a line-idle timeout.
module uart_loader #(
   parameter int DATA_WIDTH = 32,
   parameter int BPS_CNT    = 434,
   parameter int MAX_IDLE   = 500000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  rx,
   output logic [DATA_WIDTH-1:0] DataOut,
   output logic [DATA_WIDTH-1:0] Address,
   output logic                  Done
);

   localparam int CW = $clog2(BPS_CNT);
   localparam int IW = $clog2(MAX_IDLE + 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(BPS_CNT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(BPS_CNT / 2 - 1);
   localparam logic [IW-1:0] IDLE_MAX  = IW'(MAX_IDLE);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

   state_e                state_q;
   logic                  rx_s1_q, rx_s2_q, rx_s3_q;
   logic [CW-1:0]         baud_q;
   logic [2:0]            bit_q;
   logic [7:0]            shift_q;
   logic                  rx_done_q;
   logic [DATA_WIDTH-1:0] wptr_q;
   logic [IW-1:0]         idle_cnt_q;
   logic [IW-1:0]         idle_cnt_d;
   logic                  armed_q;
   logic                  rx_fall;

   assign rx_fall    = rx_s3_q & ~rx_s2_q;
   assign idle_cnt_d = idle_cnt_q + IW'(1);

   // Line idles high, so the synchroniser resets to 1 to avoid a false start edge.
   always_ff @(posedge clk) begin
      if (!reset) begin
         rx_s1_q <= 1'b1;
         rx_s2_q <= 1'b1;
         rx_s3_q <= 1'b1;
      end else begin
         rx_s1_q <= rx;
         rx_s2_q <= rx_s1_q;
         rx_s3_q <= rx_s2_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         baud_q    <= '0;
         bit_q     <= '0;
         shift_q   <= '0;
         rx_done_q <= 1'b0;
      end else begin
         rx_done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (rx_fall && !Done) begin
                  state_q <= S_START;
                  baud_q  <= '0;
                  bit_q   <= '0;
               end
            end
            S_START: begin
               if (baud_q == HALF_LAST) begin
                  baud_q  <= '0;
                  state_q <= rx_s2_q ? S_IDLE : S_DATA;
               end else begin
                  baud_q <= baud_q + CW'(1);
               end
            end
            S_DATA: begin
               if (baud_q == BIT_LAST) begin
                  baud_q  <= '0;
                  shift_q <= {rx_s2_q, shift_q[7:1]};
                  bit_q   <= bit_q + 3'd1;
                  if (bit_q == 3'd7) state_q <= S_STOP;
               end else begin
                  baud_q <= baud_q + CW'(1);
               end
            end
            S_STOP: begin
               if (baud_q == BIT_LAST) begin
                  baud_q    <= '0;
                  rx_done_q <= rx_s2_q;
                  state_q   <= S_IDLE;
               end else begin
                  baud_q <= baud_q + CW'(1);
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Accepted bytes win over the timeout; a falling edge restarts the idle count.
   always_ff @(posedge clk) begin
      if (!reset) begin
         DataOut    <= '0;
         Address    <= '0;
         Done       <= 1'b0;
         wptr_q     <= '0;
         idle_cnt_q <= '0;
         armed_q    <= 1'b0;
      end else if (rx_done_q) begin
         DataOut    <= {{(DATA_WIDTH-8){1'b0}}, shift_q};
         Address    <= wptr_q;
         wptr_q     <= wptr_q + DATA_WIDTH'(4);
         armed_q    <= 1'b1;
         idle_cnt_q <= '0;
      end else if (rx_fall) begin
         idle_cnt_q <= '0;
      end else if (armed_q && !Done && state_q == S_IDLE) begin
         idle_cnt_q <= idle_cnt_d;
         if (idle_cnt_d == IDLE_MAX) begin
            Done    <= 1'b1;
            DataOut <= '0;
         end
      end
   end

endmodule

// File: tb/tb_uart_loader.sv
// Directed bench for uart_loader: bytes, framing errors, glitches, reset and timeout.
module tb_uart_loader;

   localparam int BPS  = 16;
   localparam int MAXI = 2000;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        rx = 1'b1;
   logic [31:0] data_out;
   logic [31:0] address;
   logic        done;

   always #5 clk = ~clk;

   uart_loader #(.DATA_WIDTH(32), .BPS_CNT(BPS), .MAX_IDLE(MAXI)) dut (
      .clk     (clk),
      .reset   (reset),
      .rx      (rx),
      .DataOut (data_out),
      .Address (address),
      .Done    (done)
   );

   logic [31:0] exp_data_q[$];
   logic [31:0] exp_addr_q[$];
   logic [31:0] next_addr = 32'h0;
   int total = 0;
   int bad = 0;
   int pulses = 0;
   bit pend = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Outputs update on the edge that samples RxDone, so compare one cycle later.
   always @(negedge clk) begin
      logic [31:0] ed, ea;
      if (pend) begin
         pend = 1'b0;
         if (exp_data_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_rxdone: got data %h addr %h expected none", data_out, address);
         end else begin
            ed = exp_data_q.pop_front();
            ea = exp_addr_q.pop_front();
            chk("rx_data", data_out, ed);
            chk("rx_addr", address, ea);
         end
      end
      if (dut.rx_done_q === 1'b1) begin
         pend = 1'b1;
         pulses++;
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b, input bit good);
      if (good) begin
         exp_data_q.push_back({24'h0, b});
         exp_addr_q.push_back(next_addr);
         next_addr = next_addr + 32'd4;
      end
      rx = 1'b0;
      cyc(BPS);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         cyc(BPS);
      end
      rx = good;
      cyc(BPS);
      rx = 1'b1;
      cyc(good ? 2 : BPS + 2);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      rx = 1'b1;
      cyc(3);
      reset = 1'b1;
      next_addr = 32'h0;
      cyc(2);
   endtask

   task automatic glitch();
      rx = 1'b0;
      cyc(BPS / 5);
      rx = 1'b1;
      cyc(BPS * 2);
   endtask

   task automatic wait_done();
      for (int i = 0; i < 400 && done !== 1'b1; i++) cyc(1);
      chk("done_set", {31'h0, done}, 32'h1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int p0;
      bit held;
      // Reset state
      cyc(3);
      chk("reset_data", data_out, 32'h0);
      chk("reset_addr", address, 32'h0);
      chk("reset_done", {31'h0, done}, 32'h0);
      reset = 1'b1;
      cyc(2);

      // Single byte, then back-to-back bytes
      send(8'h55, 1'b1);
      chk("t1_done", {31'h0, done}, 32'h0);
      send(8'hAA, 1'b1);
      send(8'hBB, 1'b1);
      send(8'hCC, 1'b1);
      chk("t2_final_addr", address, 32'h0000000C);

      // Timeout: not early, then Done with DataOut cleared and Address held
      cyc(MAXI - 100);
      chk("t3_not_early", {31'h0, done}, 32'h0);
      wait_done();
      chk("t3_data", data_out, 32'h0);
      chk("t3_addr", address, 32'h0000000C);
      held = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         cyc(1);
         if (done !== 1'b1) held = 1'b0;
      end
      chk("t3_done_sticky", {31'h0, held}, 32'h1);
      p0 = pulses;
      send(8'h77, 1'b0);
      chk("t3_rx_ignored", pulses, p0);
      chk("t3_data_after", data_out, 32'h0);
      chk("t3_addr_after", address, 32'h0000000C);

      // Glitch after fresh reset; no timeout while unarmed
      do_reset();
      chk("t4_reset_done", {31'h0, done}, 32'h0);
      p0 = pulses;
      glitch();
      chk("t4_no_rxdone", pulses, p0);
      chk("t4_data", data_out, 32'h0);
      chk("t4_addr", address, 32'h0);
      cyc(MAXI + 200);
      chk("t4_unarmed_no_done", {31'h0, done}, 32'h0);

      // Framing error then a good byte
      p0 = pulses;
      send(8'hE7, 1'b0);
      chk("t5_frame_err", pulses, p0);
      chk("t5_data", data_out, 32'h0);
      send(8'h3C, 1'b1);
      send(8'h12, 1'b1);

      // Reset during DATA
      rx = 1'b0;
      cyc(BPS);
      rx = 1'b1; cyc(BPS);
      rx = 1'b0; cyc(BPS);
      rx = 1'b1; cyc(BPS / 2);
      reset = 1'b0;
      cyc(1);
      chk("t6_data", data_out, 32'h0);
      chk("t6_addr", address, 32'h0);
      chk("t6_done", {31'h0, done}, 32'h0);
      rx = 1'b1;
      cyc(2);
      reset = 1'b1;
      next_addr = 32'h0;
      cyc(BPS * 12);
      send(8'h81, 1'b1);
      chk("t6_final_data", data_out, 32'h00000081);

      // A falling edge while armed restarts the idle count
      cyc(MAXI - 300);
      glitch();
      cyc(MAXI - 300);
      chk("t7_edge_clears_idle", {31'h0, done}, 32'h0);
      wait_done();
      chk("t7_addr", address, 32'h0);

      cyc(4);
      chk("queue_empty", exp_data_q.size(), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
